// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX/MEM/WB destination scoreboard driving stall, bubble, flush, freeze and forwarding selects.
// Define HAZARD_FWD_EN to enable forwarding; hazard stalls then cover load-use only.
module hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [31:0]            i_id_instr,
  input  logic                   i_id_valid,
  input  logic                   i_id_re_rs,
  input  logic                   i_id_re_rt,
  input  logic                   i_id_we,
  input  logic [4:0]             i_id_wa,
  input  logic                   i_id_is_load,
  input  logic                   i_br_taken,
  input  logic                   i_mem_busy,
  output logic                   o_stall_if,
  output logic                   o_stall_id,
  output logic                   o_bubble_ex,
  output logic                   o_flush_if_id,
  output logic                   o_freeze,
  output logic [1:0]             o_fwd_a,
  output logic [1:0]             o_fwd_b,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);
  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] wa;
    logic       is_load;
  } sb_t;
  sb_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0] rs, rt;
  logic re_rs, re_rt, ex_a, ex_b, mem_a, mem_b, hazard, freeze, flush, stall;
  logic unused;
  function automatic logic hit(input logic re, input logic [4:0] src, input sb_t e);
    return re && e.valid && e.we && e.wa == src && src != 5'd0;
  endfunction
  assign rs     = i_id_instr[25:21];
  assign rt     = i_id_instr[20:16];
  assign re_rs  = i_id_valid & i_id_re_rs;
  assign re_rt  = i_id_valid & i_id_re_rt;
  assign unused = ^{i_id_instr[31:26], i_id_instr[15:0], wb_q, ex_q.is_load, mem_q.is_load};
  always_comb begin
    ex_a   = hit(re_rs, rs, ex_q);
    ex_b   = hit(re_rt, rt, ex_q);
    mem_a  = hit(re_rs, rs, mem_q);
    mem_b  = hit(re_rt, rt, mem_q);
`ifdef HAZARD_FWD_EN
    hazard = (ex_a | ex_b) & ex_q.is_load;
`else
    hazard = ex_a | ex_b | mem_a | mem_b;
`endif
    // reset forces every combinational control low as well
    freeze = ~i_rst & i_mem_busy;
    flush  = ~i_rst & ~i_mem_busy & i_br_taken;
    stall  = ~i_rst & ~i_mem_busy & ~i_br_taken & hazard;
    wb_d   = freeze ? wb_q : mem_q;
    mem_d  = freeze ? mem_q : ex_q;
    ex_d   = freeze ? ex_q : (stall | flush) ? sb_t'('0)
           : {i_id_valid, i_id_we && i_id_wa != 5'd0, i_id_wa, i_id_is_load};
`ifdef HAZARD_FWD_EN
    fwd_a_d = freeze ? fwd_a_q : (stall | flush) ? 2'b00 : ex_a ? 2'b01 : mem_a ? 2'b10 : 2'b00;
    fwd_b_d = freeze ? fwd_b_q : (stall | flush) ? 2'b00 : ex_b ? 2'b01 : mem_b ? 2'b10 : 2'b00;
`else
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
`endif
    cnt_d  = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end
  assign o_stall_if    = freeze | stall;
  assign o_stall_id    = freeze | stall;
  assign o_bubble_ex   = stall;
  assign o_flush_if_id = flush;
  assign o_freeze      = freeze;
  assign o_fwd_a       = fwd_a_q;
  assign o_fwd_b       = fwd_b_q;
  assign o_stall_cnt   = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus reset, saturation and mid-freeze reset sequences.
module tb_hazard_ctrl;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] ins;
    logic v, rs, rt, we;
    logic [4:0] wa;
    logic ld;
  } id_t;
  // m: 0 both builds, 1 forwarding off only, 2 forwarding on only; c0/c1 counter per build
  typedef struct {
    int m; int k;
    logic br, busy, st, bub, fl, fz;
    logic [1:0] fa, fb;
    int c0, c1;
  } vec_t;
  logic clk = 1'b0;
  logic rst, id_valid, re_rs, re_rt, id_we, id_ld, br, busy;
  logic [31:0] instr;
  logic [4:0] id_wa;
  logic stall_if, stall_id, bubble, flush, freeze;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] cnt;
  int total = 0, bad = 0;
  vec_t tv[$];
  always #5 clk = ~clk;
  hazard_ctrl #(.STALL_CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_instr(instr), .i_id_valid(id_valid),
    .i_id_re_rs(re_rs), .i_id_re_rt(re_rt), .i_id_we(id_we), .i_id_wa(id_wa),
    .i_id_is_load(id_ld), .i_br_taken(br), .i_mem_busy(busy),
    .o_stall_if(stall_if), .o_stall_id(stall_id), .o_bubble_ex(bubble),
    .o_flush_if_id(flush), .o_freeze(freeze), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
    .o_stall_cnt(cnt)
  );
  function automatic id_t dec(input int k);
    case (k)
      1: return '{32'h00221820, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0};
      2: return '{32'h00652022, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0};
      3: return '{32'h8C230000, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1};
      4: return '{32'h00632020, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0};
      5: return '{32'h00220020, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0};
      6: return '{32'h00002020, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0};
      7: return '{32'h00222820, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0};
      8: return '{32'h30250007, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0};
      default: return '0;
    endcase
  endfunction
  function automatic vec_t r(input int m, input int k, input logic b, input logic bz,
                             input logic st, input logic bu, input logic fl, input logic fz,
                             input logic [1:0] fa, input logic [1:0] fb, input int c0, input int c1);
    return '{m, k, b, bz, st, bu, fl, fz, fa, fb, c0, c1};
  endfunction
  task automatic drive(input int k, input logic b, input logic bz);
    id_t d;
    d = dec(k);
    {instr, id_valid, re_rs, re_rt, id_we, id_wa, id_ld} = d;
    br = b;
    busy = bz;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string p, input logic st, input logic bu, input logic fl,
                         input logic fz, input logic [1:0] fa, input logic [1:0] fb, input int c);
    chk({p, " stall_if"}, 32'(stall_if), 32'(st));
    chk({p, " stall_id"}, 32'(stall_id), 32'(st));
    chk({p, " bubble"}, 32'(bubble), 32'(bu));
    chk({p, " flush"}, 32'(flush), 32'(fl));
    chk({p, " freeze"}, 32'(freeze), 32'(fz));
    chk({p, " fwd_a"}, 32'(fwd_a), 32'(fa));
    chk({p, " fwd_b"}, 32'(fwd_b), 32'(fb));
    chk({p, " cnt"}, 32'(cnt), 32'(c));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tv.push_back(r(0,0,0,0, 0,0,0,0, 0,0, 0,0));
    tv.push_back(r(0,1,0,0, 0,0,0,0, 0,0, 0,0));
    tv.push_back(r(1,2,0,0, 1,1,0,0, 0,0, 0,0));
    tv.push_back(r(1,2,0,0, 1,1,0,0, 0,0, 1,0));
    tv.push_back(r(1,2,0,0, 0,0,0,0, 0,0, 2,0));
    tv.push_back(r(1,0,0,0, 0,0,0,0, 0,0, 2,0));
    tv.push_back(r(2,2,0,0, 0,0,0,0, 0,0, 0,0));
    tv.push_back(r(2,0,0,0, 0,0,0,0, 1,0, 0,0));
    tv.push_back(r(0,0,0,0, 0,0,0,0, 0,0, 2,0));
    tv.push_back(r(0,3,0,0, 0,0,0,0, 0,0, 2,0));
    tv.push_back(r(0,4,0,0, 1,1,0,0, 0,0, 2,0));
    tv.push_back(r(1,4,0,0, 1,1,0,0, 0,0, 3,0));
    tv.push_back(r(1,4,0,0, 0,0,0,0, 0,0, 4,0));
    tv.push_back(r(1,0,0,0, 0,0,0,0, 0,0, 4,0));
    tv.push_back(r(2,4,0,0, 0,0,0,0, 0,0, 0,1));
    tv.push_back(r(2,0,0,0, 0,0,0,0, 2,2, 0,1));
    tv.push_back(r(0,0,0,0, 0,0,0,0, 0,0, 4,1));
    tv.push_back(r(0,3,0,0, 0,0,0,0, 0,0, 4,1));
    tv.push_back(r(0,4,1,0, 0,0,1,0, 0,0, 4,1));
    tv.push_back(r(1,0,0,0, 0,0,0,0, 0,0, 4,1));
    tv.push_back(r(1,0,0,0, 0,0,0,0, 0,0, 4,1));
    tv.push_back(r(2,4,0,0, 0,0,0,0, 0,0, 4,1));
    tv.push_back(r(2,0,0,0, 0,0,0,0, 2,2, 4,1));
    tv.push_back(r(0,0,0,0, 0,0,0,0, 0,0, 4,1));
    tv.push_back(r(0,3,0,0, 0,0,0,0, 0,0, 4,1));
    tv.push_back(r(0,4,0,1, 1,0,0,1, 0,0, 4,1));
    tv.push_back(r(0,4,1,1, 1,0,0,1, 0,0, 4,1));
    tv.push_back(r(0,4,0,1, 1,0,0,1, 0,0, 4,1));
    tv.push_back(r(0,4,0,0, 1,1,0,0, 0,0, 4,1));
    tv.push_back(r(1,4,0,0, 1,1,0,0, 0,0, 5,1));
    tv.push_back(r(1,4,0,0, 0,0,0,0, 0,0, 6,1));
    tv.push_back(r(1,0,0,0, 0,0,0,0, 0,0, 6,1));
    tv.push_back(r(2,4,0,0, 0,0,0,0, 0,0, 6,2));
    tv.push_back(r(2,0,0,0, 0,0,0,0, 2,2, 6,2));
    tv.push_back(r(0,0,0,0, 0,0,0,0, 0,0, 6,2));
    tv.push_back(r(0,5,0,0, 0,0,0,0, 0,0, 6,2));
    tv.push_back(r(0,6,0,0, 0,0,0,0, 0,0, 6,2));
    tv.push_back(r(0,0,0,0, 0,0,0,0, 0,0, 6,2));
    tv.push_back(r(0,0,0,0, 0,0,0,0, 0,0, 6,2));
    tv.push_back(r(0,7,0,0, 0,0,0,0, 0,0, 6,2));
    tv.push_back(r(0,8,0,0, 0,0,0,0, 0,0, 6,2));
    tv.push_back(r(0,0,0,0, 0,0,0,0, 0,0, 6,2));
    tv.push_back(r(0,0,0,0, 0,0,0,0, 0,0, 6,2));
    rst = 1'b1;
    drive(0, 1'b0, 1'b0);
    #12;
    chk_all("reset", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    rst = 1'b0;
    tick();
    foreach (tv[i]) begin
      if ((tv[i].m == 1 && FWD) || (tv[i].m == 2 && !FWD)) continue;
      drive(tv[i].k, tv[i].br, tv[i].busy);
      #3;
      chk_all($sformatf("row%0d", i), tv[i].st, tv[i].bub, tv[i].fl, tv[i].fz,
              tv[i].fa, tv[i].fb, FWD ? tv[i].c1 : tv[i].c0);
      tick();
    end
    for (int n = 0; n < 20; n++) begin
      drive(3, 1'b0, 1'b0);
      tick();
      drive(4, 1'b0, 1'b0);
      tick();
    end
    drive(0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("saturate cnt", 32'(cnt), 32'd15);
    drive(3, 1'b0, 1'b0);
    tick();
    drive(4, 1'b0, 1'b1);
    #3;
    chk("pre-reset freeze", 32'(freeze), 32'd1);
    rst = 1'b1;
    #1;
    chk_all("mid-freeze reset", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick();
    #3;
    rst = 1'b0;
    busy = 1'b0;
    #1;
    chk_all("after reset", 0, 0, 0, 0, 2'b00, 2'b00, 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS32 core. It keeps a shadow scoreboard of destination registers in flight in the EX, MEM and WB stages. It compares the ID-stage source registers against that scoreboard, using the per-operand read enables from the decode stage. From that comparison it drives PC/IF-ID stall, ID/EX bubble insertion, IF/ID flush on a taken branch, a whole-pipe freeze on data-memory wait, and registered forwarding selects for the EX-stage operand muxes.

## Interface
- `STALL_CNT_W`, default 16: width of the saturating stall-cycle counter.
- `i_clk`, input, 1: pipeline clock; all state updates on the rising edge.
- `i_rst`, input, 1: asynchronous, active-high reset.
- `i_id_instr`, input, 32: instruction in ID; rs = [25:21], rt = [20:16].
- `i_id_valid`, input, 1: ID holds a real instruction (0 = bubble).
- `i_id_re_rs`, input, 1: ID instruction reads rs (from decode).
- `i_id_re_rt`, input, 1: ID instruction reads rt (from decode).
- `i_id_we`, input, 1: ID instruction writes a GPR.
- `i_id_wa`, input, 5: ID instruction destination register.
- `i_id_is_load`, input, 1: ID instruction is LW.
- `i_br_taken`, input, 1: branch/jump resolved taken in EX this cycle.
- `i_mem_busy`, input, 1: data memory not ready; pipeline must hold.
- `o_stall_if`, output, 1: hold PC.
- `o_stall_id`, output, 1: hold IF/ID register.
- `o_bubble_ex`, output, 1: load NOP into ID/EX instead of the ID instruction.
- `o_flush_if_id`, output, 1: clear IF/ID to NOP.
- `o_freeze`, output, 1: hold ID/EX, EX/MEM, MEM/WB.
- `o_fwd_a`, output, 2: EX operand A select; 00 regfile, 01 EX/MEM, 10 MEM/WB.
- `o_fwd_b`, output, 2: EX operand B select; same encoding as `o_fwd_a`.
- `o_stall_cnt`, output, STALL_CNT_W: saturating count of hazard stall cycles.

## Operation
- **Scoreboard.** Three entries, EX/MEM/WB, each {valid, we, wa, is_load}. A write to $0 is recorded with we = 0.
- **Match rule.** A source matches an entry when re = 1, entry valid, entry we, entry wa == source, and source != 0.
- **Advance** (i_mem_busy = 0):
  - WB <= MEM; MEM <= EX.
  - EX <= ID fields, or an invalid entry when o_bubble_ex = 1 or i_br_taken = 1.
- **Freeze** (i_mem_busy = 1):
  - o_freeze = o_stall_if = o_stall_id = 1; o_bubble_ex = o_flush_if_id = 0.
  - Scoreboard, o_fwd_a/b and o_stall_cnt hold.
  - i_br_taken is ignored while frozen; the EX stage is held, so the source keeps it asserted.
- **Hazard stall**, when not frozen: o_stall_if = o_stall_id = o_bubble_ex = 1.
- **Branch.** i_br_taken = 1 with no freeze gives o_flush_if_id = 1 and an invalid EX entry. A flush suppresses any hazard stall in the same cycle: stall outputs are 0 and the counter does not increment.
- **Forwarding selects.** o_fwd_a (from rs) and o_fwd_b (from rt) are registered on advance:
  - 01 if the EX entry matches (the producer will be in MEM next cycle).
  - else 10 if the MEM entry matches.
  - else 00.
  - The nearest producer wins.
  - The selects load 00 when a bubble or flush enters EX.
- **Regfile bypass.** The register file writes in the first half-cycle, so a WB-entry match never needs a stall or a forward.
- **Stall counter.** o_stall_cnt increments by 1 on every hazard-stall cycle and saturates at all-ones.

## Timing
- Reset: all outputs 0, all scoreboard entries invalid, counter 0.
- Stall, bubble, flush and freeze are combinational from the current inputs and scoreboard.
- o_fwd_a/b are valid in the cycle the consuming instruction sits in EX (1-cycle registered latency from ID).
- Load-use costs exactly 1 stall cycle. The consumer then sees fwd = 10.
- Reset asserted mid-stall or mid-freeze clears everything immediately, with no partial advance.

## Configuration
- `HAZARD_FWD_EN` defined: hazard stall = match against an EX entry with is_load = 1 (load-use only); forwarding as described above.
- Not defined:
  - o_fwd_a/b are tied to 00.
  - Hazard stall = match against the EX or MEM entry, any instruction type.
  - A back-to-back dependency costs 2 stall cycles; a distance-2 dependency costs 1.

## Test plan
- **ALU chain, fwd on.** 0x00221820 (add $3,$1,$2) then 0x00652022 (sub $4,$3,$5) -> no stall; o_fwd_a = 01, o_fwd_b = 00 while sub is in EX.
- **Load-use.** 0x8C230000 (lw $3,0($1)) then 0x00632020 (add $4,$3,$3) -> 1 cycle with stall_if/id = bubble_ex = 1; then o_fwd_a = o_fwd_b = 10; o_stall_cnt = 1.
- **Branch vs stall.** Load-use condition with i_br_taken = 1 in the same cycle -> o_flush_if_id = 1, all stall outputs 0, EX entry invalid, counter unchanged.
- **Freeze.** i_mem_busy = 1 for 3 cycles during the lw/add sequence -> o_freeze = 1 for 3 cycles, scoreboard and fwd held; the load-use stall then occurs exactly once after release.
- **$0 and reads.** add $0,$1,$2 followed by a reader of $0 -> fwd 00, no stall. A producer of $5 followed by ANDI reading $5 only via rt (i_id_re_rt = 0) -> no match.
- **Fwd off** (macro undefined). The ALU chain from the first scenario -> 2 stall cycles, o_fwd_a stays 00, o_stall_cnt = 2.
